// File: rtl/usb_speed_autodetect_if.sv
// usb_speed_autodetect_if
// Bundles the register-block controls, PHY linestate and detection results
// of the USB speed auto-detector. The clock and reset stay plain ports.
//
// Handshake: I_restart is a single-cycle request pulse that is always
// accepted. O_busy is high from the accepting edge until the result edge.
// O_done pulses for exactly one cycle on that result edge; O_speed, O_xcvrsel
// and O_termsel are valid from that edge and hold until the next I_restart.
// A restart while busy abandons the run, and that run never raises O_done.
interface usb_speed_autodetect_if #(
    parameter int pUSB_AUTO_COUNTER_WIDTH = 24
);
    logic                               I_restart;
    logic [pUSB_AUTO_COUNTER_WIDTH-1:0] I_wait1;
    logic [pUSB_AUTO_COUNTER_WIDTH-1:0] I_wait2;
    logic [1:0]                         I_xcvrsel_default;
    logic                               I_termsel_default;
    logic [1:0]                         I_linestate;
    logic [1:0]                         O_speed;
    logic [1:0]                         O_xcvrsel;
    logic                               O_termsel;
    logic                               O_busy;
    logic                               O_done;

    // Detector side
    modport slave (
        input  I_restart,
        input  I_wait1,
        input  I_wait2,
        input  I_xcvrsel_default,
        input  I_termsel_default,
        input  I_linestate,
        output O_speed,
        output O_xcvrsel,
        output O_termsel,
        output O_busy,
        output O_done
    );

    // Register block / PHY side
    modport master (
        output I_restart,
        output I_wait1,
        output I_wait2,
        output I_xcvrsel_default,
        output I_termsel_default,
        output I_linestate,
        input  O_speed,
        input  O_xcvrsel,
        input  O_termsel,
        input  O_busy,
        input  O_done
    );
endinterface

// File: rtl/usb_speed_autodetect.sv
// usb_speed_autodetect
// Passive USB bus-speed detector/sequencer for the PW-USB front end.
// After a restart it drives the default transceiver selects, waits for a
// settled attached bus, then classifies it as LS (idle K), FS (idle J, no
// chirp after bus reset) or HS (chirp K after bus reset) and drives the
// transceiver selects for the detected speed.
//
// Optional feature: define USB_AUTODETECT_DEBUG_EN to add O_dbg_state and
// O_dbg_kmax. Functional behaviour is identical either way.

`ifndef USB_SPEED_AUTO
`define USB_SPEED_AUTO 2'b00
`endif
`ifndef USB_SPEED_LS
`define USB_SPEED_LS 2'b01
`endif
`ifndef USB_SPEED_FS
`define USB_SPEED_FS 2'b10
`endif
`ifndef USB_SPEED_HS
`define USB_SPEED_HS 2'b11
`endif

module usb_speed_autodetect #(
    parameter int pUSB_AUTO_COUNTER_WIDTH = 24,
    parameter int pCHIRP_MIN_CYCLES       = 150
) (
    input  logic fe_clk,
    input  logic reset_i,
    usb_speed_autodetect_if.slave bus
`ifdef USB_AUTODETECT_DEBUG_EN
    ,
    output logic [2:0]  O_dbg_state,
    output logic [15:0] O_dbg_kmax
`endif
);

    localparam int W = pUSB_AUTO_COUNTER_WIDTH;

    localparam logic [1:0] LINE_SE0 = 2'b00;
    localparam logic [1:0] LINE_J   = 2'b01;
    localparam logic [1:0] LINE_K   = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_SETTLE     = 3'd1,
        ST_SAMPLE     = 3'd2,
        ST_WAIT_RESET = 3'd3,
        ST_CHIRP      = 3'd4,
        ST_DONE       = 3'd5
    } state_t;

    state_t       state_q, state_d;
    logic [W-1:0] timer_q, timer_d;
    logic [W-1:0] kcnt_q,  kcnt_d;
    logic [1:0]   speed_q, speed_d;
    logic [1:0]   xcvrsel_q, xcvrsel_d;
    logic         termsel_q, termsel_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;

    logic [W-1:0] wait1_eff;
    logic [W-1:0] wait2_eff;
    logic [W-1:0] timer_inc;
    logic [W-1:0] kcnt_inc;
    logic         line_active;
    logic         line_k;

    // A zero wait is treated as one cycle; counters saturate instead of wrapping.
    always_comb begin
        wait1_eff   = (bus.I_wait1 == '0) ? W'(1) : bus.I_wait1;
        wait2_eff   = (bus.I_wait2 == '0) ? W'(1) : bus.I_wait2;
        timer_inc   = (timer_q == '1) ? timer_q : timer_q + W'(1);
        kcnt_inc    = (kcnt_q  == '1) ? kcnt_q  : kcnt_q  + W'(1);
        line_k      = (bus.I_linestate == LINE_K);
        line_active = (bus.I_linestate == LINE_J) || line_k;
    end

    // Next-state and next-output logic for the detection sequence.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        kcnt_d    = kcnt_q;
        speed_d   = speed_q;
        xcvrsel_d = xcvrsel_q;
        termsel_d = termsel_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        if (bus.I_restart) begin
            // Restart always wins, even mid-run; the aborted run produces no done.
            state_d   = ST_SETTLE;
            timer_d   = '0;
            kcnt_d    = '0;
            speed_d   = `USB_SPEED_AUTO;
            xcvrsel_d = bus.I_xcvrsel_default;
            termsel_d = bus.I_termsel_default;
            busy_d    = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                end

                ST_SETTLE: begin
                    // Any SE0/SE1 means the bus is not yet stable: start over.
                    if (line_active) begin
                        timer_d = timer_inc;
                        if (timer_inc >= wait1_eff) begin
                            state_d = ST_SAMPLE;
                        end
                    end else begin
                        timer_d = '0;
                    end
                end

                ST_SAMPLE: begin
                    if (line_k) begin
                        state_d   = ST_DONE;
                        speed_d   = `USB_SPEED_LS;
                        xcvrsel_d = 2'b10;
                        termsel_d = 1'b1;
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
                    end else if (bus.I_linestate == LINE_J) begin
                        state_d = ST_WAIT_RESET;
                    end else begin
                        state_d = ST_SETTLE;
                        timer_d = '0;
                    end
                end

                ST_WAIT_RESET: begin
                    // Full-speed-capable device: wait for the host's bus reset.
                    if (bus.I_linestate == LINE_SE0) begin
                        state_d = ST_CHIRP;
                        timer_d = '0;
                        kcnt_d  = '0;
                    end
                end

                ST_CHIRP: begin
                    timer_d = timer_inc;
                    kcnt_d  = line_k ? kcnt_inc : '0;
                    // A qualifying K run takes priority over window expiry.
                    if (line_k && (kcnt_inc >= W'(pCHIRP_MIN_CYCLES))) begin
                        state_d   = ST_DONE;
                        speed_d   = `USB_SPEED_HS;
                        xcvrsel_d = 2'b00;
                        termsel_d = 1'b0;
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
                    end else if (timer_inc >= wait2_eff) begin
                        state_d   = ST_DONE;
                        speed_d   = `USB_SPEED_FS;
                        xcvrsel_d = 2'b01;
                        termsel_d = 1'b1;
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
                    end
                end

                ST_DONE: begin
                    state_d = ST_IDLE;
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge fe_clk or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            kcnt_q    <= '0;
            speed_q   <= `USB_SPEED_AUTO;
            xcvrsel_q <= 2'b01;
            termsel_q <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            kcnt_q    <= kcnt_d;
            speed_q   <= speed_d;
            xcvrsel_q <= xcvrsel_d;
            termsel_q <= termsel_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.O_speed   = speed_q;
    assign bus.O_xcvrsel = xcvrsel_q;
    assign bus.O_termsel = termsel_q;
    assign bus.O_busy    = busy_q;
    assign bus.O_done    = done_q;

`ifdef USB_AUTODETECT_DEBUG_EN
    logic [15:0] kmax_q, kmax_d;
    logic [31:0] kcnt_wide;
    logic [15:0] krun_16;

    // Longest K run of the current/last chirp window, saturating at 16 bits.
    always_comb begin
        kcnt_wide = 32'(kcnt_inc);
        krun_16   = (kcnt_wide > 32'h0000_FFFF) ? 16'hFFFF : kcnt_wide[15:0];
        kmax_d    = kmax_q;
        if (bus.I_restart) begin
            kmax_d = '0;
        end else if ((state_q == ST_CHIRP) && line_k && (krun_16 > kmax_q)) begin
            kmax_d = krun_16;
        end
    end

    // Debug K-run register.
    always_ff @(posedge fe_clk or posedge reset_i) begin
        if (reset_i) begin
            kmax_q <= '0;
        end else begin
            kmax_q <= kmax_d;
        end
    end

    assign O_dbg_state = state_q;
    assign O_dbg_kmax  = kmax_q;
`endif

endmodule

// File: tb/tb_usb_speed_autodetect.sv
// tb_usb_speed_autodetect
// Directed scenarios for the USB speed auto-detector, checked every cycle
// against a phase-level behavioural model, plus literal result/latency checks.

`ifndef USB_SPEED_AUTO
`define USB_SPEED_AUTO 2'b00
`endif
`ifndef USB_SPEED_LS
`define USB_SPEED_LS 2'b01
`endif
`ifndef USB_SPEED_FS
`define USB_SPEED_FS 2'b10
`endif
`ifndef USB_SPEED_HS
`define USB_SPEED_HS 2'b11
`endif

module tb_usb_speed_autodetect;

    localparam int W         = 24;
    localparam int CHIRP_MIN = 150;
    localparam int SAT       = (1 << W) - 1;

    localparam logic [1:0] SE0 = 2'b00;
    localparam logic [1:0] J   = 2'b01;
    localparam logic [1:0] K   = 2'b10;

    localparam logic [1:0] SPD_AUTO = `USB_SPEED_AUTO;
    localparam logic [1:0] SPD_LS   = `USB_SPEED_LS;
    localparam logic [1:0] SPD_FS   = `USB_SPEED_FS;
    localparam logic [1:0] SPD_HS   = `USB_SPEED_HS;

    localparam logic [1:0] DEF_XCVR = 2'b11;
    localparam logic       DEF_TERM = 1'b0;

    // Model phases
    localparam int P_IDLE    = 0;
    localparam int P_SETTLE  = 1;
    localparam int P_SAMPLE  = 2;
    localparam int P_WAITRST = 3;
    localparam int P_CHIRP   = 4;
    localparam int P_DONE    = 5;

    logic fe_clk;
    logic reset_i;

    usb_speed_autodetect_if #(.pUSB_AUTO_COUNTER_WIDTH(W)) bus ();

    usb_speed_autodetect #(
        .pUSB_AUTO_COUNTER_WIDTH(W),
        .pCHIRP_MIN_CYCLES(CHIRP_MIN)
    ) dut (
        .fe_clk(fe_clk),
        .reset_i(reset_i),
        .bus(bus)
    );

    // ---------------- clock ----------------
    initial fe_clk = 1'b0;
    always #5 fe_clk = ~fe_clk;

    // ---------------- counters ----------------
    int n_checks = 0;
    int n_errors = 0;
    int edge_cnt = 0;
    int done_edge = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int         m_phase = P_IDLE;
    int         m_run   = 0;   // consecutive J/K cycles while settling
    int         m_age   = 0;   // cycles since bus reset began
    int         m_krun  = 0;   // current consecutive K run in chirp window
    logic [1:0] m_speed = SPD_AUTO;
    logic [1:0] m_xs    = 2'b01;
    logic       m_ts    = 1'b1;
    logic       m_busy  = 1'b0;
    logic       m_done  = 1'b0;

    task automatic model_reset();
        m_phase = P_IDLE;
        m_run   = 0;
        m_age   = 0;
        m_krun  = 0;
        m_speed = SPD_AUTO;
        m_xs    = 2'b01;
        m_ts    = 1'b1;
        m_busy  = 1'b0;
        m_done  = 1'b0;
    endtask

    task automatic model_finish(input logic [1:0] spd);
        m_phase = P_DONE;
        m_busy  = 1'b0;
        m_done  = 1'b1;
        m_speed = spd;
        case (spd)
            SPD_HS:  begin m_xs = 2'b00; m_ts = 1'b0; end
            SPD_FS:  begin m_xs = 2'b01; m_ts = 1'b1; end
            default: begin m_xs = 2'b10; m_ts = 1'b1; end
        endcase
    endtask

    // Advance the model by one clock edge using the inputs of the ending cycle.
    task automatic model_step();
        logic [1:0] ls;
        int thr1;
        int thr2;
        ls   = bus.I_linestate;
        thr1 = (bus.I_wait1 == 0) ? 1 : int'(bus.I_wait1);
        thr2 = (bus.I_wait2 == 0) ? 1 : int'(bus.I_wait2);
        if (reset_i) begin
            model_reset();
            return;
        end
        m_done = 1'b0;
        if (bus.I_restart) begin
            m_phase = P_SETTLE;
            m_run   = 0;
            m_busy  = 1'b1;
            m_speed = SPD_AUTO;
            m_xs    = bus.I_xcvrsel_default;
            m_ts    = bus.I_termsel_default;
            return;
        end
        case (m_phase)
            P_SETTLE: begin
                if (ls == J || ls == K) begin
                    if (m_run < SAT) m_run++;
                    if (m_run >= thr1) m_phase = P_SAMPLE;
                end else begin
                    m_run = 0;
                end
            end
            P_SAMPLE: begin
                if (ls == K) model_finish(SPD_LS);
                else if (ls == J) m_phase = P_WAITRST;
                else begin
                    m_phase = P_SETTLE;
                    m_run   = 0;
                end
            end
            P_WAITRST: begin
                if (ls == SE0) begin
                    m_phase = P_CHIRP;
                    m_age   = 0;
                    m_krun  = 0;
                end
            end
            P_CHIRP: begin
                if (m_age < SAT) m_age++;
                m_krun = (ls == K) ? m_krun + 1 : 0;
                if (m_krun >= CHIRP_MIN) model_finish(SPD_HS);
                else if (m_age >= thr2) model_finish(SPD_FS);
            end
            P_DONE: m_phase = P_IDLE;
            default: ;
        endcase
    endtask

    // ---------------- compare process ----------------
    initial begin
        forever begin
            @(negedge fe_clk);
            check("speed",   32'(bus.O_speed),   32'(m_speed));
            check("xcvrsel", 32'(bus.O_xcvrsel), 32'(m_xs));
            check("termsel", 32'(bus.O_termsel), 32'(m_ts));
            check("busy",    32'(bus.O_busy),    32'(m_busy));
            check("done",    32'(bus.O_done),    32'(m_done));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input logic r, input logic [1:0] ls);
        bus.I_restart   = r;
        bus.I_linestate = ls;
        @(posedge fe_clk);
        model_step();
        #1;
        edge_cnt++;
        if (bus.O_done === 1'b1 && done_edge == 0) done_edge = edge_cnt;
    endtask

    task automatic hold(input logic [1:0] ls, input int n);
        for (int i = 0; i < n; i++) tick(1'b0, ls);
    endtask

    task automatic mark();
        edge_cnt  = 0;
        done_edge = 0;
    endtask

    task automatic check_result(input string tag, input logic [1:0] spd,
                                input logic [1:0] xs, input logic ts);
        check({tag, "_speed"},   32'(bus.O_speed),   32'(spd));
        check({tag, "_xcvrsel"}, 32'(bus.O_xcvrsel), 32'(xs));
        check({tag, "_termsel"}, 32'(bus.O_termsel), 32'(ts));
        check({tag, "_busy"},    32'(bus.O_busy),    32'(1'b0));
    endtask

    // Reach WAIT_RESET with an idle-J bus, then issue a one-cycle SE0.
    task automatic fs_setup();
        tick(1'b1, J);
        hold(J, 120);
        tick(1'b0, SE0);
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        reset_i               = 1'b1;
        bus.I_restart         = 1'b0;
        bus.I_wait1           = W'(100);
        bus.I_wait2           = W'(1000);
        bus.I_xcvrsel_default = DEF_XCVR;
        bus.I_termsel_default = DEF_TERM;
        bus.I_linestate       = SE0;
        model_reset();
        repeat (3) @(posedge fe_clk);
        #1;
        check("rst_speed",   32'(bus.O_speed),   32'(2'b00));
        check("rst_xcvrsel", 32'(bus.O_xcvrsel), 32'(2'b01));
        check("rst_termsel", 32'(bus.O_termsel), 32'(1'b1));
        check("rst_busy",    32'(bus.O_busy),    32'(1'b0));
        check("rst_done",    32'(bus.O_done),    32'(1'b0));
        reset_i = 1'b0;
        hold(J, 3);

        // LS: K held, wait1=50 -> done 52 cycles counting the restart cycle
        bus.I_wait1 = W'(50);
        mark();
        tick(1'b1, K);
        check("ls_busy_start", 32'(bus.O_busy), 32'(1'b1));
        check("ls_xcvr_def",   32'(bus.O_xcvrsel), 32'(DEF_XCVR));
        hold(K, 60);
        check("ls_latency", 32'(done_edge), 32'd52);
        check_result("ls", SPD_LS, 2'b10, 1'b1);

        // FS: no chirp, done 1000 cycles into the reset window
        bus.I_wait1 = W'(100);
        fs_setup();
        mark();
        hold(J, 1100);
        check("fs_latency", 32'(done_edge), 32'd1000);
        check_result("fs", SPD_FS, 2'b01, 1'b1);

        // HS: chirp K, done on the 150th consecutive K
        fs_setup();
        mark();
        hold(K, 200);
        check("hs_latency", 32'(done_edge), 32'd150);
        check_result("hs", SPD_HS, 2'b00, 1'b0);

        // Settle glitch: SE0 restarts the settle count
        bus.I_wait1 = W'(50);
        tick(1'b1, J);
        hold(J, 40);
        tick(1'b0, SE0);
        hold(J, 49);
        mark();
        hold(K, 10);
        check("glitch_latency", 32'(done_edge), 32'd2);
        check_result("glitch", SPD_LS, 2'b10, 1'b1);

        // Short chirp runs of 149 K never qualify -> FS
        bus.I_wait1 = W'(100);
        fs_setup();
        mark();
        hold(K, 149);
        hold(J, 1);
        hold(K, 149);
        hold(J, 750);
        check("short_latency", 32'(done_edge), 32'd1000);
        check_result("short", SPD_FS, 2'b01, 1'b1);

        // HS qualify and wait2 expiry on the same edge -> HS
        bus.I_wait2 = W'(150);
        fs_setup();
        mark();
        hold(K, 160);
        check("tie_latency", 32'(done_edge), 32'd150);
        check_result("tie", SPD_HS, 2'b00, 1'b0);

        // wait1=0 behaves as 1
        bus.I_wait1 = W'(0);
        mark();
        tick(1'b1, K);
        hold(K, 5);
        check("w1zero_latency", 32'(done_edge), 32'd3);
        check_result("w1zero", SPD_LS, 2'b10, 1'b1);

        // wait2=0 behaves as 1
        bus.I_wait1 = W'(100);
        bus.I_wait2 = W'(0);
        fs_setup();
        mark();
        hold(J, 5);
        check("w2zero_latency", 32'(done_edge), 32'd1);
        check_result("w2zero", SPD_FS, 2'b01, 1'b1);

        // Abort mid-chirp: no done, defaults restored, busy stays high
        bus.I_wait2 = W'(1000);
        fs_setup();
        hold(K, 100);
        mark();
        tick(1'b1, J);
        hold(J, 30);
        check("abort_no_done", 32'(done_edge), 32'd0);
        check("abort_busy",    32'(bus.O_busy),    32'(1'b1));
        check("abort_speed",   32'(bus.O_speed),   32'(SPD_AUTO));
        check("abort_xcvrsel", 32'(bus.O_xcvrsel), 32'(DEF_XCVR));
        check("abort_termsel", 32'(bus.O_termsel), 32'(DEF_TERM));
        hold(J, 80);
        tick(1'b0, SE0);
        mark();
        hold(J, 1005);
        check("abort_rerun", 32'(done_edge), 32'd1000);

        // Async reset mid-SETTLE takes effect without a clock edge
        tick(1'b1, J);
        hold(J, 20);
        #1;
        reset_i = 1'b1;
        model_reset();
        #1;
        check("arst_speed",   32'(bus.O_speed),   32'(2'b00));
        check("arst_xcvrsel", 32'(bus.O_xcvrsel), 32'(2'b01));
        check("arst_termsel", 32'(bus.O_termsel), 32'(1'b1));
        check("arst_busy",    32'(bus.O_busy),    32'(1'b0));
        check("arst_done",    32'(bus.O_done),    32'(1'b0));
        hold(J, 2);
        reset_i = 1'b0;
        hold(J, 3);

        // Recovery after reset
        bus.I_wait1 = W'(50);
        mark();
        tick(1'b1, K);
        hold(K, 60);
        check("recover_latency", 32'(done_edge), 32'd52);
        check_result("recover", SPD_LS, 2'b10, 1'b1);

        @(negedge fe_clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
